uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter BPS, default 9_600, serial baud rate in bits/s.
REQ-002 Parameter CLK_FRE, default 50_000_000, sys_clk frequency in Hz.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1, number of stop bits, legal values 1 or 2.
REQ-005 sys_clk  input  1  system clock; the only clock; all logic on its rising edge.
REQ-006 sys_rst_n  input  1  reset, synchronous, active-low.
REQ-007 uart_tx_en  input  1  byte-valid request from user logic.
REQ-008 uart_tx_data  input  8  byte to send; sampled only on acceptance.
REQ-009 uart_tx_ready  output  1  high when a new byte can be accepted.
REQ-010 uart_tx_busy  output  1  high while a frame is on the line.
REQ-011 uart_tx_done  output  1  one-cycle pulse at frame completion.
REQ-012 uart_txd  output  1  serial transmit line; idle high.

Function
REQ-013 BPS_CNT SHALL equal CLK_FRE / BPS (integer division); every serial bit SHALL last exactly BPS_CNT sys_clk cycles.
REQ-014 States SHALL be IDLE, START, DATA, PARITY, STOP; reset state IDLE.
REQ-015 Acceptance SHALL occur on a cycle where uart_tx_en and uart_tx_ready are both high; uart_tx_data SHALL be latched into an internal shift register on that edge.
REQ-016 uart_tx_ready SHALL be high only in IDLE; uart_tx_en while not ready SHALL be ignored, without queuing.
REQ-017 Cycle after acceptance: state START, uart_txd low, uart_tx_busy high, baud counter at 0.
REQ-018 Bit order: start bit (0), data LSB first (bit 0..7), optional parity bit, then STOP_BITS stop bits (1).
REQ-019 Parity bit, when PARITY != 0: even = XOR of the 8 data bits; odd = its inverse; PARITY == 0 SHALL skip the PARITY state.
REQ-020 Baud counter: 32-bit, counts 0..BPS_CNT-1 and wraps to 0; state/bit index SHALL advance only on the wrap cycle.
REQ-021 Bit index: 3-bit for DATA, 1-bit for STOP; DATA SHALL exit after index 7 wraps, STOP after STOP_BITS bits.
REQ-022 Frame length SHALL be (10 + (PARITY!=0) + (STOP_BITS-1)) x BPS_CNT cycles from the first START cycle to the last STOP cycle inclusive.
REQ-023 At the final STOP wrap: uart_tx_done high for exactly one cycle (the next cycle), state IDLE, uart_tx_ready high, uart_tx_busy low in that same cycle.
REQ-024 Back-to-back: uart_tx_en held high SHALL be accepted in the first IDLE cycle, giving exactly one idle-high cycle between frames.
REQ-025 uart_txd SHALL be driven from a register, glitch-free, high in IDLE and STOP.
REQ-026 uart_tx_data changes after acceptance SHALL NOT affect the frame in flight.

Reset
REQ-027 With sys_rst_n low at a rising edge: state IDLE, uart_txd 1, uart_tx_ready 1, uart_tx_busy 0, uart_tx_done 0, counters 0, shift register 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame: uart_txd returns high on the next edge, and no done pulse is issued.
REQ-029 Acceptance SHALL NOT occur in a cycle where sys_rst_n is low.

Structure
REQ-030 Shared package uart_pkg SHALL hold the state enum typedef, parity mode constants (PAR_NONE/PAR_ODD/PAR_EVEN), and the BPS_CNT computation function, for reuse by uart_rx.
REQ-031 The baud counter SHALL be one sub-module, uart_baud_gen (inputs clear/enable, output one-cycle bit_tick on wrap), reusable by the receiver.
REQ-032 Illegal PARITY (>2) or STOP_BITS (not 1/2) SHALL fail at elaboration.

Verification (bench uses CLK_FRE=1000, BPS=100 -> BPS_CNT=10)
REQ-033 PARITY=0, STOP_BITS=1; send 0x55 -> uart_txd 0,1,0,1,0,1,0,1,0,1 each 10 cycles; done pulse 100 cycles after first START cycle.
REQ-034 PARITY=2; send 0x07 -> parity bit 1; PARITY=1, send 0x07 -> parity bit 0; frame 110 cycles.
REQ-035 STOP_BITS=2; send 0xA3 -> 20 high stop cycles, frame 110 cycles, single done pulse.
REQ-036 uart_tx_en held high with data 0x12 then 0x34 -> two frames, exactly one idle cycle between them, loopback via uart_rx returns 0x12, 0x34.
REQ-037 Pulse uart_tx_en during busy with 0xFF -> ignored; in-flight byte 0x3C unchanged on line.
REQ-038 Assert sys_rst_n low at cycle 45 of a frame -> uart_txd high next edge, no done, ready high after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity modes and the
// baud divider computation, used by both uart_tx and uart_rx.
package uart_pkg;

    // Frame sequencer states, shared with the receiver.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_e;

    // Parity modes.
    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Number of sys_clk cycles per serial bit (integer division).
    function automatic int unsigned calc_bps_cnt(
        input int unsigned clk_fre,
        input int unsigned bps
    );
        return clk_fre / bps;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..BPS_CNT-1 while enabled and wraps.
// Ports: clk, rst_n (sync, active-low), clear, enable -> bit_tick.
//   bit_tick is high for the single cycle in which the counter wraps.
module uart_baud_gen #(
    parameter int unsigned BPS_CNT = 5208
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);

    localparam logic [31:0] CNT_LAST = BPS_CNT - 32'd1;

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic        wrap;

    assign wrap     = enable && (cnt_q == CNT_LAST);
    assign bit_tick = wrap && !clear;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = 32'd0;
        end else if (enable) begin
            cnt_d = wrap ? 32'd0 : cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional parity, 1 or 2 stops.
// Ports: sys_clk, sys_rst_n (sync, active-low), uart_tx_en/uart_tx_data
//   (request, accepted when ready), uart_tx_ready, uart_tx_busy,
//   uart_tx_done (one-cycle pulse at frame end), uart_txd (serial out).
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned BPS       = 9_600,
    parameter int unsigned CLK_FRE   = 50_000_000,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_tx_en,
    input  logic [7:0] uart_tx_data,
    output logic       uart_tx_ready,
    output logic       uart_tx_busy,
    output logic       uart_tx_done,
    output logic       uart_txd
);

    localparam int unsigned BPS_CNT = calc_bps_cnt(CLK_FRE, BPS);

    // Stop index value of the final stop bit.
    localparam logic STOP_LAST = (STOP_BITS == 2);
    localparam logic HAS_PAR   = (PARITY != PAR_NONE);
    localparam logic PAR_INV   = (PARITY == PAR_ODD);

    if (PARITY > 2) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    if (BPS_CNT == 0) begin : g_bad_baud
        $error("uart_tx: CLK_FRE must be at least BPS");
    end

    uart_state_e state_q;
    uart_state_e state_d;
    logic [7:0]  shift_q;
    logic [7:0]  shift_d;
    logic        par_q;
    logic        par_d;
    logic [2:0]  bit_idx_q;
    logic [2:0]  bit_idx_d;
    logic        stop_idx_q;
    logic        stop_idx_d;
    logic        txd_q;
    logic        txd_d;
    logic        busy_q;
    logic        busy_d;
    logic        ready_q;
    logic        ready_d;
    logic        done_q;
    logic        done_d;

    logic        baud_clear;
    logic        bit_tick;
    logic        accept;

    // The counter is held at zero while idle so the first START cycle
    // always begins a full bit period.
    assign baud_clear = (state_q == S_IDLE);
    assign accept     = uart_tx_en && ready_q;

    uart_baud_gen #(
        .BPS_CNT (BPS_CNT)
    ) u_baud_gen (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .clear    (baud_clear),
        .enable   (!baud_clear),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        par_d      = par_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        ready_d    = ready_q;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (accept) begin
                    state_d    = S_START;
                    shift_d    = uart_tx_data;
                    par_d      = (^uart_tx_data) ^ PAR_INV;
                    bit_idx_d  = 3'd0;
                    stop_idx_d = 1'b0;
                    txd_d      = 1'b0;
                    busy_d     = 1'b1;
                    ready_d    = 1'b0;
                end
            end

            S_START: begin
                if (bit_tick) begin
                    state_d = S_DATA;
                    txd_d   = shift_q[0];
                end
            end

            S_DATA: begin
                if (bit_tick) begin
                    // The line always shows shift_q[0]; shifting exposes
                    // the next data bit.
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        if (HAS_PAR) begin
                            state_d = S_PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d = S_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        txd_d = shift_q[1];
                    end
                end
            end

            S_PARITY: begin
                if (bit_tick) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                end
            end

            S_STOP: begin
                txd_d = 1'b1;
                if (bit_tick) begin
                    if (stop_idx_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            shift_q    <= 8'd0;
            par_q      <= 1'b0;
            bit_idx_q  <= 3'd0;
            stop_idx_q <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign uart_txd      = txd_q;
    assign uart_tx_busy  = busy_q;
    assign uart_tx_ready = ready_q;
    assign uart_tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with BPS_CNT = 10 across four parameter sets.
// Instances: 0 no parity/1 stop, 1 even, 2 odd, 3 no parity/2 stops.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data;
    logic [3:0] en;
    logic [3:0] ready;
    logic [3:0] busy;
    logic [3:0] done;
    logic [3:0] txd;

    int checks = 0;
    int errors = 0;

    logic cap_txd   [0:255];
    logic cap_done  [0:255];
    logic cap_busy  [0:255];
    logic cap_ready [0:255];

    always #5 clk = ~clk;

    uart_tx #(.BPS(100), .CLK_FRE(1000), .PARITY(0), .STOP_BITS(1)) u_p0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .uart_tx_en(en[0]),
        .uart_tx_data(data), .uart_tx_ready(ready[0]),
        .uart_tx_busy(busy[0]), .uart_tx_done(done[0]), .uart_txd(txd[0]));

    uart_tx #(.BPS(100), .CLK_FRE(1000), .PARITY(2), .STOP_BITS(1)) u_pe (
        .sys_clk(clk), .sys_rst_n(rst_n), .uart_tx_en(en[1]),
        .uart_tx_data(data), .uart_tx_ready(ready[1]),
        .uart_tx_busy(busy[1]), .uart_tx_done(done[1]), .uart_txd(txd[1]));

    uart_tx #(.BPS(100), .CLK_FRE(1000), .PARITY(1), .STOP_BITS(1)) u_po (
        .sys_clk(clk), .sys_rst_n(rst_n), .uart_tx_en(en[2]),
        .uart_tx_data(data), .uart_tx_ready(ready[2]),
        .uart_tx_busy(busy[2]), .uart_tx_done(done[2]), .uart_txd(txd[2]));

    uart_tx #(.BPS(100), .CLK_FRE(1000), .PARITY(0), .STOP_BITS(2)) u_s2 (
        .sys_clk(clk), .sys_rst_n(rst_n), .uart_tx_en(en[3]),
        .uart_tx_data(data), .uart_tx_ready(ready[3]),
        .uart_tx_busy(busy[3]), .uart_tx_done(done[3]), .uart_txd(txd[3]));

    // Request one byte; returns at the negedge of the first START cycle.
    task automatic start_frame(input int k, input logic [7:0] b);
        @(negedge clk);
        data  = b;
        en[k] = 1'b1;
        @(negedge clk);
        en[k] = 1'b0;
    endtask

    task automatic sample(input int k, input int c);
        cap_txd[c]   = txd[k];
        cap_done[c]  = done[k];
        cap_busy[c]  = busy[k];
        cap_ready[c] = ready[k];
    endtask

    // Capture n cycles starting with the current one.
    task automatic grab(input int k, input int n);
        for (int c = 0; c < n; c++) begin
            if (c > 0) @(negedge clk);
            sample(k, c);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 4'h0;
        data  = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (ready !== 4'hF) begin
            errors++;
            $display("FAIL reset_ready got %b want 1111", ready);
        end
        checks++;
        if (busy !== 4'h0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0000", busy);
        end
        checks++;
        if (done !== 4'h0) begin
            errors++;
            $display("FAIL reset_done got %b want 0000", done);
        end
        checks++;
        if (txd !== 4'hF) begin
            errors++;
            $display("FAIL reset_txd got %b want 1111", txd);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (ready !== 4'hF || txd !== 4'hF) begin
            errors++;
            $display("FAIL post_reset got ready %b txd %b want 1111 1111",
                     ready, txd);
        end
    endtask

    task automatic test_basic();
        logic [9:0] exp;
        int bad;
        int first;
        int pulses;
        exp = 10'b1_01010101_0;
        start_frame(0, 8'h55);
        grab(0, 105);
        for (int j = 0; j < 10; j++) begin
            bad = 0;
            for (int i = 0; i < 10; i++)
                if (cap_txd[j*10+i] !== exp[j]) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL basic_bit%0d got %0d wrong cycles want 0",
                         j, bad);
            end
        end
        first  = -1;
        pulses = 0;
        for (int c = 0; c < 105; c++)
            if (cap_done[c] === 1'b1) begin
                pulses++;
                if (first < 0) first = c;
            end
        checks++;
        if (first != 100 || pulses != 1) begin
            errors++;
            $display("FAIL basic_done got at %0d x%0d want at 100 x1",
                     first, pulses);
        end
        checks++;
        if (cap_busy[0] !== 1'b1 || cap_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_start got busy %b ready %b want 1 0",
                     cap_busy[0], cap_ready[0]);
        end
        checks++;
        if (cap_busy[100] !== 1'b0 || cap_ready[100] !== 1'b1
            || cap_busy[99] !== 1'b1) begin
            errors++;
            $display("FAIL basic_end got busy %b ready %b want 0 1",
                     cap_busy[100], cap_ready[100]);
        end
    endtask

    task automatic test_parity(input int k, input logic p, input string nm);
        logic [10:0] exp;
        int bad;
        int first;
        exp = {1'b1, p, 8'h07, 1'b0};
        start_frame(k, 8'h07);
        grab(k, 115);
        bad = 0;
        for (int i = 90; i < 100; i++)
            if (cap_txd[i] !== p) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_parity got %0d wrong cycles want bit %b",
                     nm, bad, p);
        end
        bad = 0;
        for (int j = 0; j < 11; j++)
            for (int i = 0; i < 10; i++)
                if (cap_txd[j*10+i] !== exp[j]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_frame got %0d wrong cycles want 0", nm, bad);
        end
        first = -1;
        for (int c = 0; c < 115; c++)
            if (cap_done[c] === 1'b1 && first < 0) first = c;
        checks++;
        if (first != 110) begin
            errors++;
            $display("FAIL %s_done got %0d want 110", nm, first);
        end
    endtask

    task automatic test_stop2();
        logic [7:0] got;
        int highs;
        int first;
        int pulses;
        start_frame(3, 8'hA3);
        grab(3, 115);
        for (int i = 0; i < 8; i++) got[i] = cap_txd[10*(i+1)+5];
        checks++;
        if (got !== 8'hA3) begin
            errors++;
            $display("FAIL stop2_data got %h want a3", got);
        end
        highs = 0;
        for (int c = 90; c < 110; c++)
            if (cap_txd[c] === 1'b1 && cap_busy[c] === 1'b1) highs++;
        checks++;
        if (highs != 20) begin
            errors++;
            $display("FAIL stop2_len got %0d high cycles want 20", highs);
        end
        first  = -1;
        pulses = 0;
        for (int c = 0; c < 115; c++)
            if (cap_done[c] === 1'b1) begin
                pulses++;
                if (first < 0) first = c;
            end
        checks++;
        if (first != 110 || pulses != 1) begin
            errors++;
            $display("FAIL stop2_done got at %0d x%0d want at 110 x1",
                     first, pulses);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b0;
        logic [7:0] b1;
        int idle;
        int pulses;
        @(negedge clk);
        data  = 8'h12;
        en[0] = 1'b1;
        @(negedge clk);
        data = 8'h34;
        for (int c = 0; c < 215; c++) begin
            if (c > 0) @(negedge clk);
            sample(0, c);
            if (c == 101) en[0] = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            b0[i] = cap_txd[10*(i+1)+5];
            b1[i] = cap_txd[101+10*(i+1)+5];
        end
        checks++;
        if (b0 !== 8'h12) begin
            errors++;
            $display("FAIL b2b_first got %h want 12", b0);
        end
        checks++;
        if (b1 !== 8'h34) begin
            errors++;
            $display("FAIL b2b_second got %h want 34", b1);
        end
        idle = 0;
        for (int c = 0; c <= 200; c++)
            if (cap_busy[c] !== 1'b1) idle++;
        checks++;
        if (idle != 1 || cap_txd[100] !== 1'b1 || cap_txd[101] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap got %0d idle txd %b%b want 1 idle 10",
                     idle, cap_txd[100], cap_txd[101]);
        end
        pulses = 0;
        for (int c = 0; c < 215; c++)
            if (cap_done[c] === 1'b1) pulses++;
        checks++;
        if (pulses != 2 || cap_done[100] !== 1'b1 || cap_done[201] !== 1'b1)
        begin
            errors++;
            $display("FAIL b2b_done got %0d pulses want 2 at 100 and 201",
                     pulses);
        end
    endtask

    task automatic test_ignore_busy();
        logic [7:0] got;
        int pulses;
        int bad;
        start_frame(0, 8'h3C);
        for (int c = 0; c < 115; c++) begin
            if (c > 0) @(negedge clk);
            sample(0, c);
            if (c == 25) begin
                data  = 8'hFF;
                en[0] = 1'b1;
            end
            if (c == 26) en[0] = 1'b0;
        end
        for (int i = 0; i < 8; i++) got[i] = cap_txd[10*(i+1)+5];
        checks++;
        if (got !== 8'h3C) begin
            errors++;
            $display("FAIL ignore_data got %h want 3c", got);
        end
        pulses = 0;
        for (int c = 0; c < 115; c++)
            if (cap_done[c] === 1'b1) pulses++;
        checks++;
        if (pulses != 1 || cap_done[100] !== 1'b1) begin
            errors++;
            $display("FAIL ignore_done got %0d pulses want 1 at 100", pulses);
        end
        bad = 0;
        for (int c = 100; c < 115; c++)
            if (cap_busy[c] !== 1'b0 || cap_txd[c] !== 1'b1) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ignore_idle got %0d busy cycles want 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        int pulses;
        start_frame(0, 8'h00);
        for (int c = 0; c < 131; c++) begin
            if (c > 0) @(negedge clk);
            sample(0, c);
            if (c == 45) rst_n = 1'b0;
            if (c == 48) rst_n = 1'b1;
        end
        checks++;
        if (cap_txd[45] !== 1'b0 || cap_txd[46] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_txd got %b%b want 01",
                     cap_txd[45], cap_txd[46]);
        end
        checks++;
        if (cap_busy[46] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_busy got %b want 0", cap_busy[46]);
        end
        pulses = 0;
        bad    = 0;
        for (int c = 46; c < 131; c++) begin
            if (cap_done[c] === 1'b1) pulses++;
            if (cap_txd[c] !== 1'b1) bad++;
        end
        checks++;
        if (pulses != 0 || bad != 0) begin
            errors++;
            $display("FAIL rstmid_abort got %0d done %0d low want 0 0",
                     pulses, bad);
        end
        checks++;
        if (cap_ready[49] !== 1'b1 || cap_ready[130] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready got %b%b want 11",
                     cap_ready[49], cap_ready[130]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity(1, 1'b1, "even");
        test_parity(2, 1'b0, "odd");
        test_stop2();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
